// File: rtl/alu_pkg.sv
// Shared ALU opcode, FSM state and width definitions for the ALU request arbiter.
package alu_pkg;

  localparam int ALUOP_W = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response channels, ALU drive and status of the ALU request arbiter.
interface alu_req_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int CW   = 16
) ();
  logic [NREQ-1:0]                  req_valid;
  logic [NREQ-1:0]                  req_ready;
  logic [NREQ*DW-1:0]               req_a;
  logic [NREQ*DW-1:0]               req_b;
  logic [NREQ*alu_pkg::ALUOP_W-1:0] req_op;
  logic [DW-1:0]                    alu_a;
  logic [DW-1:0]                    alu_b;
  logic [alu_pkg::ALUOP_W-1:0]      alu_op;
  logic [DW-1:0]                    alu_c;
  logic                             alu_zero;
  logic [NREQ-1:0]                  rsp_valid;
  logic [NREQ-1:0]                  rsp_ready;
  logic [DW-1:0]                    rsp_result;
  logic                             rsp_zero;
  logic                             busy;
  logic [CW-1:0]                    op_count;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_c, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero,
           busy, op_count
  );

  // Requester / ALU side
  modport master (
    output req_valid, req_a, req_b, req_op, alu_c, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_zero,
           busy, op_count
  );
endinterface

// File: rtl/alu_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after i_last, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  always_comb begin
    logic w_found;
    w_found = 1'b0;
    o_gnt   = '0;
    o_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && i_req[(int'(i_last) + k) % NREQ]) begin
        w_found                           = 1'b1;
        o_gnt[(int'(i_last) + k) % NREQ]  = 1'b1;
        o_idx                             = IW'((int'(i_last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one combinational ALU: accept, execute one cycle, hold response.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input logic              clk,
  input logic              rst,
  alu_req_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              r_state, w_next;
  logic [IW-1:0]       r_last, r_gidx, w_idx;
  logic [NREQ-1:0]     w_gnt, w_req_ready, w_rsp_valid;
  logic                w_accept, w_done;
  logic [DW-1:0]       r_a, r_b, r_result;
  logic [ALUOP_W-1:0]  r_op;
  logic                r_zero;
  logic [CW-1:0]       r_cnt;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // req_ready is gated by rst so nothing is advertised while reset is held
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_req_ready = '0;
    w_rsp_valid = '0;
    case (r_state)
      IDLE: begin
        if (|bus.req_valid && !rst) begin
          w_accept    = 1'b1;
          w_req_ready = w_gnt;
          w_next      = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        w_rsp_valid = NREQ'(1) << r_gidx;
        if (bus.rsp_ready[r_gidx]) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= ALU_NOP;
      r_gidx   <= '0;
      r_last   <= IW'(NREQ - 1);
      r_result <= '0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= bus.req_a[int'(w_idx)*DW +: DW];
        r_b    <= bus.req_b[int'(w_idx)*DW +: DW];
        r_op   <= bus.req_op[int'(w_idx)*ALUOP_W +: ALUOP_W];
        r_gidx <= w_idx;
        r_last <= w_idx;
      end
      if (r_state == EXEC) begin
        r_result <= bus.alu_c;
        r_zero   <= bus.alu_zero;
      end
      if (w_done) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.alu_op     = r_op;
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign bus.busy       = (r_state != IDLE);
  assign bus.op_count   = r_cnt;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.NREQ(2), .DW(32), .CW(16)) b0 ();
  alu_req_arbiter_if #(.NREQ(3), .DW(32), .CW(4))  b1 ();

  alu_req_arbiter #(.NREQ(2), .DW(32), .CW(16)) d0 (.clk(clk), .rst(rst), .bus(b0));
  alu_req_arbiter #(.NREQ(3), .DW(32), .CW(4))  d1 (.clk(clk), .rst(rst), .bus(b1));

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign b0.alu_c    = alu_f(b0.alu_a, b0.alu_b, b0.alu_op);
  assign b0.alu_zero = (b0.alu_c == 32'd0);
  assign b1.alu_c    = alu_f(b1.alu_a, b1.alu_b, b1.alu_op);
  assign b1.alu_zero = (b1.alu_c == 32'd0);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int ngr, nrs;
  int gcyc[6];
  int gidx[6];

  initial begin
    b0.req_valid = '0; b0.req_a = '0; b0.req_b = '0; b0.req_op = '0; b0.rsp_ready = '0;
    b1.req_valid = '0; b1.req_a = '0; b1.req_b = '0; b1.req_op = '0; b1.rsp_ready = '0;

    // reset state, with requests pending to prove req_ready stays low
    b0.req_valid = 2'b11;
    cyc(); cyc(); settle();
    chk("rst_busy",   32'(b0.busy), 0);
    chk("rst_rdy",    32'(b0.req_ready), 0);
    chk("rst_rv",     32'(b0.rsp_valid), 0);
    chk("rst_res",    b0.rsp_result, 0);
    chk("rst_zero",   32'(b0.rsp_zero), 0);
    chk("rst_alu_a",  b0.alu_a, 0);
    chk("rst_alu_op", 32'(b0.alu_op), 32'(ALU_NOP));
    chk("rst_cnt",    32'(b0.op_count), 0);
    b0.req_valid = '0;
    cyc(); rst = 1'b0;

    // 1: single ADD on requester 0
    cyc();
    b0.req_valid = 2'b01;
    b0.req_a = {32'd0, 32'd5}; b0.req_b = {32'd0, 32'd7};
    b0.req_op = {ALU_NOP, ALU_ADD};
    settle();
    chk("t1_rdy",   32'(b0.req_ready), 2'b01);
    chk("t1_idle",  32'(b0.busy), 0);
    cyc(); b0.req_valid = '0; settle();
    chk("t1_alu_a", b0.alu_a, 5);
    chk("t1_alu_op", 32'(b0.alu_op), 32'(ALU_ADD));
    chk("t1_busy",  32'(b0.busy), 1);
    chk("t1_rv_ex", 32'(b0.rsp_valid), 0);
    cyc(); settle();
    chk("t1_rv",    32'(b0.rsp_valid), 2'b01);
    chk("t1_res",   b0.rsp_result, 12);
    chk("t1_zero",  32'(b0.rsp_zero), 0);
    b0.rsp_ready = 2'b01;
    cyc(); b0.rsp_ready = '0; settle();
    chk("t1_cnt",   32'(b0.op_count), 1);
    chk("t1_rv_off", 32'(b0.rsp_valid), 0);

    // 2: SUB on requester 1, response stalled 4 cycles, requester 0 waiting
    cyc();
    b0.req_valid = 2'b10;
    b0.req_a = {32'd9, 32'd77}; b0.req_b = {32'd9, 32'd1};
    b0.req_op = {ALU_SUB, ALU_ADD};
    settle();
    chk("t2_rdy", 32'(b0.req_ready), 2'b10);
    cyc(); b0.req_valid = 2'b01; settle();
    chk("t2_rdy_ex", 32'(b0.req_ready), 0);
    chk("t2_busy_ex", 32'(b0.busy), 1);
    for (int k = 0; k < 4; k++) begin
      cyc(); settle();
      chk($sformatf("t2_rv%0d", k),   32'(b0.rsp_valid), 2'b10);
      chk($sformatf("t2_res%0d", k),  b0.rsp_result, 0);
      chk($sformatf("t2_zero%0d", k), 32'(b0.rsp_zero), 1);
      chk($sformatf("t2_busy%0d", k), 32'(b0.busy), 1);
      chk($sformatf("t2_rdy%0d", k),  32'(b0.req_ready), 0);
    end
    b0.rsp_ready = 2'b10; b0.req_valid = '0;
    cyc(); b0.rsp_ready = '0; settle();
    chk("t2_cnt",  32'(b0.op_count), 2);
    chk("t2_idle", 32'(b0.busy), 0);

    // 3: both requesters valid continuously, six operations
    b0.req_a = {32'd50, 32'd100}; b0.req_b = {32'd8, 32'd1};
    b0.req_op = {ALU_SUB, ALU_ADD};
    cyc();
    b0.req_valid = 2'b11; b0.rsp_ready = 2'b11;
    ngr = 0; nrs = 0;
    for (int c = 0; c < 40 && nrs < 6; c++) begin
      if (ngr == 6) b0.req_valid = '0;
      settle();
      if (b0.req_ready != '0 && ngr < 6) begin
        gidx[ngr] = b0.req_ready[1] ? 1 : 0;
        gcyc[ngr] = c;
        ngr++;
      end
      if (b0.rsp_valid != '0) begin
        chk($sformatf("t3_res%0d", nrs), b0.rsp_result, b0.rsp_valid[0] ? 32'd101 : 32'd42);
        nrs++;
      end
      cyc();
    end
    b0.rsp_ready = '0; b0.req_valid = '0;
    chk("t3_ngr", 32'(ngr), 6);
    chk("t3_nrs", 32'(nrs), 6);
    for (int k = 0; k < ngr; k++) begin
      chk($sformatf("t3_gnt%0d", k), 32'(gidx[k]), 32'(k % 2));
      if (k > 0) chk($sformatf("t3_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 3);
    end
    settle();
    chk("t3_cnt", 32'(b0.op_count), 8);

    // 6: rsp_ready on the non-granted requester is ignored
    cyc();
    b0.req_valid = 2'b01;
    b0.req_a = {32'd0, 32'h0000_00F0}; b0.req_b = {32'd0, 32'h0000_003C};
    b0.req_op = {ALU_NOP, ALU_AND};
    settle();
    chk("t6_rdy", 32'(b0.req_ready), 2'b01);
    cyc(); b0.req_valid = '0;
    cyc(); settle();
    chk("t6_rv",  32'(b0.rsp_valid), 2'b01);
    chk("t6_res", b0.rsp_result, 32'h30);
    b0.rsp_ready = 2'b10;
    for (int k = 0; k < 2; k++) begin
      cyc(); settle();
      chk($sformatf("t6_rv_hold%0d", k), 32'(b0.rsp_valid), 2'b01);
      chk($sformatf("t6_busy%0d", k),    32'(b0.busy), 1);
      chk($sformatf("t6_cnt%0d", k),     32'(b0.op_count), 8);
    end
    b0.rsp_ready = 2'b01;
    cyc(); b0.rsp_ready = '0; settle();
    chk("t6_cnt", 32'(b0.op_count), 9);

    // 4: reset during EXEC drops the in-flight operation
    cyc();
    b0.req_valid = 2'b01;
    b0.req_a = {32'd0, 32'd1}; b0.req_b = {32'd0, 32'd2};
    b0.req_op = {ALU_NOP, ALU_ADD};
    settle();
    chk("t4_rdy", 32'(b0.req_ready), 2'b01);
    cyc(); b0.req_valid = '0; settle();
    chk("t4_alu_a", b0.alu_a, 1);
    chk("t4_exec",  32'(b0.busy), 1);
    rst = 1'b1;
    settle();
    chk("t4_busy",   32'(b0.busy), 0);
    chk("t4_alu_a0", b0.alu_a, 0);
    chk("t4_alu_op", 32'(b0.alu_op), 32'(ALU_NOP));
    chk("t4_rv",     32'(b0.rsp_valid), 0);
    chk("t4_cnt",    32'(b0.op_count), 0);
    chk("t4_res",    b0.rsp_result, 0);
    cyc(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); settle();
      chk($sformatf("t4_norsp%0d", k), 32'(b0.rsp_valid), 0);
    end
    b0.req_valid = 2'b11;
    b0.req_a = {32'd20, 32'd1}; b0.req_b = {32'd30, 32'd2};
    settle();
    chk("t4_first", 32'(b0.req_ready), 2'b01);
    cyc(); b0.req_valid = '0;
    cyc(); settle();
    chk("t4_rv2",  32'(b0.rsp_valid), 2'b01);
    chk("t4_res2", b0.rsp_result, 3);
    b0.rsp_ready = 2'b01;
    cyc(); b0.rsp_ready = '0;

    // 5: op_count wrap, on a narrow-counter instance (CW=4, NREQ=3)
    b1.req_a = {32'd0, 32'd0, 32'd3}; b1.req_b = {32'd0, 32'd0, 32'd4};
    b1.req_op = {ALU_NOP, ALU_NOP, ALU_ADD};
    b1.req_valid = 3'b001; b1.rsp_ready = 3'b001;
    for (int c = 0; c < 100 && b1.op_count != 4'd15; c++) cyc();
    chk("t5_pre", 32'(b1.op_count), 15);
    for (int c = 0; c < 10 && b1.op_count == 4'd15; c++) cyc();
    chk("t5_wrap", 32'(b1.op_count), 0);
    b1.req_valid = '0; b1.rsp_ready = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
